// File: rtl/io_port_controller_if.sv
// Handshake/bus bundle between io_port_controller, the CPU flag logic and the external byte source/sink.
// The controller takes the slave modport; the CPU/device side takes master.
interface io_port_controller_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] INPR;
    logic              FGI;
    logic              inp_ack;
    logic [DATA_W-1:0] OUTR_in;
    logic              out_load;
    logic              FGO;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, inp_ack, OUTR_in, out_load, out_ready,
        input  in_ready, INPR, FGI, FGO, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, inp_ack, OUTR_in, out_load, out_ready,
        output in_ready, INPR, FGI, FGO, out_data, out_valid
    );
endinterface

// File: rtl/io_port_controller.sv
// Peripheral partner of the Basic Computer I/O flags: source bytes -> INPR/FGI, OUTR -> sink with FGO recovery.
// Optional feature macro IOPC_RX_FIFO_EN: replaces the single INPR register with a FIFO_DEPTH-entry input buffer.
module io_port_controller #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int OUT_GAP    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    io_port_controller_if.slave  io
);

    localparam int GAP_W = (OUT_GAP > 0) ? $clog2(OUT_GAP + 1) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("io_port_controller: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [DATA_W-1:0] inpr_q;
    logic [DATA_W-1:0] inpr_d;
    logic              in_ready;
    logic              push;
    logic              fgi;

`ifdef IOPC_RX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_next;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pop;

    always_comb begin
        in_ready = rst_n & (cnt_q != CNT_FULL);
        push     = io.in_valid & in_ready;
        pop      = io.inp_ack & (cnt_q != '0);
        rd_next  = rd_ptr_q + 1'b1;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_next : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        // INPR is a registered copy of the head, so the next head is chosen one cycle ahead.
        inpr_d   = inpr_q;
        if (pop) begin
            if (cnt_q > CNT_ONE) begin
                inpr_d = mem_q[rd_next];
            end else if (push) begin
                inpr_d = io.in_data;
            end
        end else if (push && cnt_q == '0) begin
            inpr_d = io.in_data;
        end
        fgi = (cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            inpr_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            inpr_q   <= inpr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= io.in_data;
        end
    end
`else
    logic fgi_q, fgi_d;

    always_comb begin
        in_ready = rst_n & ~fgi_q;
        push     = io.in_valid & in_ready;
        inpr_d   = inpr_q;
        fgi_d    = fgi_q;
        if (push) begin
            inpr_d = io.in_data;
            fgi_d  = 1'b1;
        end else if (io.inp_ack) begin
            fgi_d  = 1'b0;
        end
        fgi = fgi_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fgi_q  <= 1'b0;
            inpr_q <= '0;
        end else begin
            fgi_q  <= fgi_d;
            inpr_q <= inpr_d;
        end
    end
`endif

    assign io.in_ready = in_ready;
    assign io.INPR     = inpr_q;
    assign io.FGI      = fgi;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_GAP
    } tx_state_t;

    tx_state_t         tx_state_q;
    logic              fgo_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [GAP_W-1:0]  gap_cnt_q;

    // FGO is 1 exactly in TX_IDLE, so a load is accepted only there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            fgo_q       <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            gap_cnt_q   <= '0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (io.out_load) begin
                        out_data_q  <= io.OUTR_in;
                        fgo_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        tx_state_q  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (io.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (OUT_GAP == 0) begin
                            fgo_q      <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            gap_cnt_q  <= GAP_W'(OUT_GAP);
                            tx_state_q <= TX_GAP;
                        end
                    end
                end
                TX_GAP: begin
                    if (gap_cnt_q == GAP_W'(1)) begin
                        fgo_q      <= 1'b1;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        gap_cnt_q  <= gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    tx_state_q <= TX_IDLE;
                end
            endcase
        end
    end

    assign io.FGO       = fgo_q;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;

endmodule

// File: tb/tb_io_port_controller.sv
// Directed bench for io_port_controller: two instances (OUT_GAP=0 and OUT_GAP=3) share stimulus and are
// checked every cycle against a queue/timestamp model, plus literal expectations at key points.
module tb_io_port_controller;

`ifdef IOPC_RX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       inp_ack;
    logic [7:0] outr_in;
    logic       out_load;
    logic       out_ready;

    io_port_controller_if #(.DATA_W(8)) ifc0 ();
    io_port_controller_if #(.DATA_W(8)) ifc3 ();

    assign ifc0.in_data   = in_data;
    assign ifc0.in_valid  = in_valid;
    assign ifc0.inp_ack   = inp_ack;
    assign ifc0.OUTR_in   = outr_in;
    assign ifc0.out_load  = out_load;
    assign ifc0.out_ready = out_ready;
    assign ifc3.in_data   = in_data;
    assign ifc3.in_valid  = in_valid;
    assign ifc3.inp_ack   = inp_ack;
    assign ifc3.OUTR_in   = outr_in;
    assign ifc3.out_load  = out_load;
    assign ifc3.out_ready = out_ready;

    io_port_controller #(.DATA_W(8), .FIFO_DEPTH(4), .OUT_GAP(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc0)
    );

    io_port_controller #(.DATA_W(8), .FIFO_DEPTH(4), .OUT_GAP(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: RX is a bounded queue; TX tracks "byte outstanding" and the edge index of the last sink handshake.
    logic [7:0] rxq[$];
    logic [7:0] m_inpr;
    int         gap_of[2] = '{0, 3};
    bit         m_busy[2];
    logic [7:0] m_od[2];
    longint     m_hs[2];
    longint     cyc = 0;

    function automatic bit m_fgo(input int i);
        return !m_busy[i] && (cyc - m_hs[i] >= longint'(gap_of[i]));
    endfunction

    logic       fgo_w[2], ov_w[2], fgi_w[2], rdy_w[2];
    logic [7:0] od_w[2], inpr_w[2];
    assign fgo_w[0] = ifc0.FGO;       assign fgo_w[1] = ifc3.FGO;
    assign ov_w[0]  = ifc0.out_valid; assign ov_w[1]  = ifc3.out_valid;
    assign od_w[0]  = ifc0.out_data;  assign od_w[1]  = ifc3.out_data;
    assign fgi_w[0] = ifc0.FGI;       assign fgi_w[1] = ifc3.FGI;
    assign rdy_w[0] = ifc0.in_ready;  assign rdy_w[1] = ifc3.in_ready;
    assign inpr_w[0] = ifc0.INPR;     assign inpr_w[1] = ifc3.INPR;

    always @(posedge clk) begin
        bit rdy, do_push, do_pop, fg;
        if (!rst_n) begin
            rxq.delete();
            m_inpr = 8'h00;
            for (int i = 0; i < 2; i++) begin
                m_busy[i] = 1'b0;
                m_od[i]   = 8'h00;
                m_hs[i]   = -1000;
            end
        end else begin
            rdy     = (rxq.size() < CAP);
            do_push = in_valid && rdy;
            do_pop  = inp_ack && (rxq.size() > 0);
            if (do_pop) void'(rxq.pop_front());
            if (do_push) rxq.push_back(in_data);
            if (rxq.size() > 0) m_inpr = rxq[0];
            for (int i = 0; i < 2; i++) begin
                fg = m_fgo(i);
                if (m_busy[i] && out_ready) begin
                    m_busy[i] = 1'b0;
                    m_hs[i]   = cyc + 1;
                end else if (fg && out_load) begin
                    m_busy[i] = 1'b1;
                    m_od[i]   = outr_in;
                end
            end
        end
        cyc++;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("u%0d_fgo", i),       fgo_w[i],  m_fgo(i));
            chk($sformatf("u%0d_out_valid", i), ov_w[i],   m_busy[i]);
            chk($sformatf("u%0d_out_data", i),  od_w[i],   m_od[i]);
            chk($sformatf("u%0d_fgi", i),       fgi_w[i],  rxq.size() > 0);
            chk($sformatf("u%0d_in_ready", i),  rdy_w[i],  rst_n && (rxq.size() < CAP));
            chk($sformatf("u%0d_inpr", i),      inpr_w[i], m_inpr);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0; inp_ack = 1'b0;
        outr_in = 8'h00; out_load = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_fgo", ifc0.FGO, 1);
        chk("rst_fgi", ifc0.FGI, 0);
        chk("rst_in_ready", ifc0.in_ready, 0);
        chk("rst_inpr", ifc0.INPR, 8'h00);
        chk("rst_out_valid", ifc3.out_valid, 0);

        // Single byte in, then consumed by INP
        rst_n = 1'b1; in_data = 8'hA5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("t1_fgi", ifc0.FGI, 1);
        chk("t1_inpr", ifc0.INPR, 8'hA5);
        chk("t1_in_ready", ifc0.in_ready, CAP > 1);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        chk("t1_fgi_clr", ifc0.FGI, 0);
        chk("t1_inpr_keep", ifc0.INPR, 8'hA5);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        chk("t1_ack_idle", ifc0.FGI, 0);

`ifndef IOPC_RX_FIFO_EN
        // Held byte waits for INP; INPR untouched meanwhile
        in_data = 8'h11; in_valid = 1'b1;
        tick();
        in_data = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_inpr_hold", ifc0.INPR, 8'h11);
            chk("t2_in_ready", ifc0.in_ready, 0);
        end
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        chk("t2_fgi_fall", ifc0.FGI, 0);
        chk("t2_inpr_old", ifc0.INPR, 8'h11);
        tick();
        in_valid = 1'b0;
        chk("t2_fgi_new", ifc0.FGI, 1);
        chk("t2_inpr_new", ifc0.INPR, 8'h3C);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
`endif

        // Output byte held until sink ready; gap behaviour on the OUT_GAP=3 instance
        outr_in = 8'h7E; out_load = 1'b1;
        tick();
        out_load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_out_valid", ifc0.out_valid, 1);
            chk("t3_out_data", ifc0.out_data, 8'h7E);
            chk("t3_fgo", ifc0.FGO, 0);
            if (i < 4) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_ov_drop", ifc0.out_valid, 0);
        chk("t3_fgo_up", ifc0.FGO, 1);
        chk("t4_ov_drop", ifc3.out_valid, 0);
        chk("t4_fgo_gap1", ifc3.FGO, 0);
        outr_in = 8'h55; out_load = 1'b1;
        tick();
        out_load = 1'b0;
        chk("t4_fgo_gap2", ifc3.FGO, 0);
        chk("t4_od_keep", ifc3.out_data, 8'h7E);
        chk("t4_ov_keep", ifc3.out_valid, 0);
        chk("t3_load55", ifc0.out_data, 8'h55);
        tick();
        chk("t4_fgo_gap3", ifc3.FGO, 0);
        tick();
        chk("t4_fgo_back", ifc3.FGO, 1);
        outr_in = 8'h9A; out_load = 1'b1;
        tick();
        out_load = 1'b0;
        chk("t4_load_at_fgo", ifc3.out_data, 8'h9A);
        chk("t4_ov_at_fgo", ifc3.out_valid, 1);
        chk("t3_busy_ignore", ifc0.out_data, 8'h55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t3_fgo_2", ifc0.FGO, 1);
        repeat (4) tick();
        chk("t4_fgo_final", ifc3.FGO, 1);

`ifdef IOPC_RX_FIFO_EN
        // Fill, full push+ack, drain in order
        in_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = 8'(i);
            tick();
        end
        chk("t5_full_rdy", ifc0.in_ready, 0);
        chk("t5_head", ifc0.INPR, 8'h01);
        in_data = 8'h05; inp_ack = 1'b1;
        #1 chk("t5_full_ack_rdy", ifc0.in_ready, 0);
        tick();
        in_valid = 1'b0;
        chk("t5_pop1", ifc0.INPR, 8'h02);
        tick();
        chk("t5_pop2", ifc0.INPR, 8'h03);
        tick();
        chk("t5_pop3", ifc0.INPR, 8'h04);
        tick();
        inp_ack = 1'b0;
        chk("t5_empty", ifc0.FGI, 0);

        in_data = 8'h21; in_valid = 1'b1;
        tick();
        in_data = 8'h22; inp_ack = 1'b1;
        tick();
        in_valid = 1'b0; inp_ack = 1'b0;
        chk("t5_pp_fgi", ifc0.FGI, 1);
        chk("t5_pp_inpr", ifc0.INPR, 8'h22);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
`endif

        // Reset mid-transfer with buffered input
        in_data = 8'hAA; in_valid = 1'b1;
        tick();
        in_data = 8'hBB;
        tick();
        in_valid = 1'b0; outr_in = 8'h66; out_load = 1'b1;
        tick();
        out_load = 1'b0;
        chk("t6_sending", ifc0.out_valid, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_ov", ifc0.out_valid, 0);
        chk("t6_fgo", ifc0.FGO, 1);
        chk("t6_fgi", ifc0.FGI, 0);
        chk("t6_inpr", ifc0.INPR, 8'h00);
        chk("t6_fgo3", ifc3.FGO, 1);
        rst_n = 1'b1;
        tick();
        chk("t6_rdy_after", ifc0.in_ready, 1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
